// File: rtl/decoder_scan_sequencer_pkg.sv
// decoder_scan_sequencer_pkg: scan FSM state encoding and decoder select width
package decoder_scan_sequencer_pkg;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BLANK = 2'd1, ST_ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/decoder_scan_sequencer_phase_timer.sv
// scan_phase_timer: 8-bit loadable down-counter; tc flags that the coming cycle ends the phase
module scan_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);
  logic [7:0] count;
  assign tc = load ? (load_val == 8'd1) : (count == 8'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? (load_val == 8'd0 ? 8'd0 : load_val - 8'd1) : (count == 8'd0 ? 8'd0 : count - 8'd1);
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: blanked slot scanner driving a 3-to-8 decoder select/enable
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned NUM_SLOTS    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             oneshot,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             slot_done,
  output logic             frame_done,
  output logic             busy
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SLOTS - 1);
  localparam logic [7:0] PRE = 8'(PRESCALE);
  localparam logic [7:0] BLK = 8'(BLANK_CYCLES);
  localparam state_t FIRST = (BLANK_CYCLES == 0) ? ST_ACTIVE : ST_BLANK;
  state_t state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [7:0] load_val;
  logic last, tc, load, stop, en_n, slot_n, frame_n, busy_n;
  scan_phase_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );
  // last marks the final cycle of the current phase; outputs are registered one edge ahead
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      en         <= 1'b0;
      slot_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      last       <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      en         <= en_n;
      slot_done  <= slot_n;
      frame_done <= frame_n;
      busy       <= busy_n;
      last       <= tc;
    end
  always_comb begin
    stop     = !run || (sel == LAST_SEL && oneshot);
    state_n  = state == ST_IDLE ? (run ? FIRST : ST_IDLE) :
               !last ? state :
               state == ST_BLANK ? ST_ACTIVE :
               stop ? ST_IDLE : FIRST;
    sel_n    = state_n == ST_IDLE ? '0 :
               (state == ST_ACTIVE && last) ? (sel == LAST_SEL ? '0 : sel + 1'b1) : sel;
    load     = state == ST_IDLE || last;
    load_val = state_n == ST_ACTIVE ? PRE : BLK;
  end
  always_comb begin
    en_n    = state_n == ST_ACTIVE;
    slot_n  = en_n && tc;
    frame_n = slot_n && sel_n == LAST_SEL;
    busy_n  = state_n != ST_IDLE;
  end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: three configurations checked every cycle against a position-based scan model
module tb_decoder_scan_sequencer;
  localparam int BL [3] = '{1, 0, 1};
  localparam int PR [3] = '{4, 2, 1};
  localparam int NS [3] = '{8, 3, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  logic oneshot = 1'b0;
  logic [2:0] sel [3];
  logic en [3];
  logic sd [3];
  logic fd [3];
  logic busy [3];
  bit running [3] = '{default: 1'b0};
  int pos [3] = '{default: 0};
  bit chk_en = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  decoder_scan_sequencer u_d0 (
    .clk(clk), .rst_n(rst_n), .run(run), .oneshot(oneshot),
    .sel(sel[0]), .en(en[0]), .slot_done(sd[0]), .frame_done(fd[0]), .busy(busy[0])
  );
  decoder_scan_sequencer #(.PRESCALE(2), .BLANK_CYCLES(0), .NUM_SLOTS(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .run(run), .oneshot(oneshot),
    .sel(sel[1]), .en(en[1]), .slot_done(sd[1]), .frame_done(fd[1]), .busy(busy[1])
  );
  decoder_scan_sequencer #(.PRESCALE(1), .BLANK_CYCLES(1), .NUM_SLOTS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .run(run), .oneshot(oneshot),
    .sel(sel[2]), .en(en[2]), .slot_done(sd[2]), .frame_done(fd[2]), .busy(busy[2])
  );
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask
  // model: pos counts cycles since the scan started; slot, phase and sel follow by division
  function automatic logic [6:0] exp_vec(input int k);
    int l, off, slot;
    logic s_d;
    if (!running[k]) return '0;
    l = BL[k] + PR[k];
    off = pos[k] % l;
    slot = (pos[k] / l) % NS[k];
    s_d = off == l - 1;
    return {3'(slot), off >= BL[k], s_d, s_d && slot == NS[k] - 1, 1'b1};
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 3; k++)
      if (!rst_n) running[k] <= 1'b0;
      else if (!running[k]) begin
        if (run) begin
          running[k] <= 1'b1;
          pos[k] <= 0;
        end
      end else if (pos[k] % (BL[k] + PR[k]) == BL[k] + PR[k] - 1 &&
                   (!run || (oneshot && (pos[k] / (BL[k] + PR[k])) % NS[k] == NS[k] - 1)))
        running[k] <= 1'b0;
      else pos[k] <= pos[k] + 1;
  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 3; k++)
        check($sformatf("model_cfg%0d", k), {sel[k], en[k], sd[k], fd[k], busy[k]}, exp_vec(k));
  initial begin
    int c_sd [3];
    int c_fd [3];
    int c_en;
    bit saw4;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", {sel[0], en[0], sd[0], fd[0], busy[0]}, 7'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    c_sd = '{default: 0};
    c_fd = '{default: 0};
    c_en = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        c_sd[k] += int'(sd[k]);
        c_fd[k] += int'(fd[k]);
      end
      c_en += int'(en[1]);
    end
    check("free_run_slot_done", 7'(c_sd[0]), 7'd16);
    check("free_run_frame_done", 7'(c_fd[0]), 7'd2);
    check("noblank_slot_done", 7'(c_sd[1]), 7'd40);
    check("noblank_frame_done", 7'(c_fd[1]), 7'd13);
    check("noblank_en_high", 7'(c_en), 7'd80);
    check("single_slot_done", 7'(c_sd[2]), 7'd40);
    check("single_frame_done", 7'(c_fd[2]), 7'd40);
    for (int i = 0; i < 200 && !(sel[0] == 3'd3 && en[0]); i++) @(negedge clk);
    check("find_sel3_active", {5'd0, sel[0] == 3'd3, en[0]}, 7'd3);
    @(negedge clk);
    run = 1'b0;
    c_en = 0;
    c_sd[0] = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      c_en += int'(en[0]);
      c_sd[0] += int'(sd[0]);
    end
    check("stop_en_remaining", 7'(c_en), 7'd3);
    check("stop_slot_done", 7'(c_sd[0]), 7'd1);
    @(negedge clk);
    check("stop_idle", {2'd0, busy[0], en[0], sel[0]}, 7'd0);
    saw4 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw4 |= sel[0] == 3'd4;
    end
    check("stop_no_sel4", {6'd0, saw4}, 7'd0);
    oneshot = 1'b1;
    run = 1'b1;
    c_sd[0] = 0;
    c_fd[0] = 0;
    repeat (40) begin
      @(negedge clk);
      c_sd[0] += int'(sd[0]);
      c_fd[0] += int'(fd[0]);
    end
    check("oneshot_slot_done", 7'(c_sd[0]), 7'd8);
    check("oneshot_frame_done", 7'(c_fd[0]), 7'd1);
    @(negedge clk);
    check("oneshot_idle", {2'd0, busy[0], en[0], sel[0]}, 7'd0);
    run = 1'b0;
    oneshot = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 200 && !(sel[0] == 3'd5 && en[0]); i++) @(negedge clk);
    check("find_sel5_active", {5'd0, sel[0] == 3'd5, en[0]}, 7'd3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {sel[0], en[0], sd[0], fd[0], busy[0]}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !en[0]; i++) @(negedge clk);
    check("restart_sel0", {3'd0, en[0], sel[0]}, 7'b0001000);
    run = 1'b0;
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
